// File: rtl/sys_proto_pkg.sv
// sys_proto_pkg: opcodes, framing bytes, FSM state types and argument-count helper for the MCU<->FPGA UART protocol
package sys_proto_pkg;
  localparam logic [2:0] OP_GET_CONF = 3'd1;
  localparam logic [2:0] OP_SET_CONF = 3'd2;
  localparam logic [2:0] OP_OVL_EN   = 3'd3;
  localparam logic [2:0] OP_MOVE     = 3'd4;
  localparam logic [2:0] OP_PRINT    = 3'd5;
  localparam logic [2:0] OP_SEL      = 3'd6;
  localparam logic [2:0] OP_LOAD     = 3'd7;
  localparam logic [7:0] JOY_START   = 8'h01;
  localparam logic [7:0] STR_TERM    = 8'h00;
  typedef enum logic [2:0] {TX_IDLE, TX_OPC, TX_ARGS, TX_STR, TX_DATA, TX_WAIT_CFG} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_JOY, R_STR} rx_state_t;
  function automatic logic [2:0] arg_bytes(input logic [2:0] op);
    return op == OP_SET_CONF ? 3'd4 :
           op == OP_LOAD ? 3'd3 :
           op == OP_MOVE ? 3'd2 :
           (op == OP_OVL_EN || op == OP_SEL) ? 3'd1 : 3'd0;
  endfunction
endpackage

// File: rtl/sys_host_rxparse.sv
// sys_host_rxparse: return-stream parser holding joypad registers and the config-string buffer
// Ports: rx_data/rx_valid byte strobe in; cfg_start arms a string capture, cfg_abort cancels it;
// joy1/joy2/joy_update joypad frame out; cfg_rd_addr/cfg_rd_data buffer read (1-cycle);
// cfg_len/cfg_done/cfg_pending string status.
module sys_host_rxparse import sys_proto_pkg::*; #(
  parameter int STR_MAX = 128,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  output logic              cfg_pending,
  output logic [15:0]       joy1,
  output logic [15:0]       joy2,
  output logic              joy_update,
  input  logic [ADDR_W-1:0] cfg_rd_addr,
  output logic [7:0]        cfg_rd_data,
  output logic [ADDR_W:0]   cfg_len,
  output logic              cfg_done
);
  logic [7:0] mem [STR_MAX];
  rx_state_t st;
  logic [1:0] idx;
  logic [23:0] jb;
  logic [ADDR_W:0] cnt;
  logic we;
  logic [ADDR_W-1:0] wa;
  // cnt's top bit set means the buffer is full; further bytes are dropped
  always_comb begin
    we = rx_valid && rx_data != STR_TERM &&
         ((st == R_IDLE && rx_data != JOY_START && cfg_pending) || (st == R_STR && !cnt[ADDR_W]));
    wa = st == R_STR ? cnt[ADDR_W-1:0] : '0;
  end
  always_ff @(posedge clk)
    if (we) mem[wa] <= rx_data;
  always_ff @(posedge clk)
    cfg_rd_data <= reset ? '0 : mem[cfg_rd_addr];
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= R_IDLE;
      idx <= '0;
      jb <= '0;
      cnt <= '0;
      joy1 <= '0;
      joy2 <= '0;
      joy_update <= 1'b0;
      cfg_len <= '0;
      cfg_done <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      joy_update <= 1'b0;
      cfg_done <= 1'b0;
      if (cfg_start) cfg_pending <= 1'b1;
      if (rx_valid) begin
        case (st)
          R_IDLE: begin
            if (rx_data == JOY_START) begin
              st <= R_JOY;
              idx <= '0;
            end else if (cfg_pending) begin
              // an immediate terminator is an empty string
              if (rx_data == STR_TERM) begin
                cfg_len <= '0;
                cfg_done <= 1'b1;
                cfg_pending <= 1'b0;
              end else begin
                st <= R_STR;
                cnt <= (ADDR_W+1)'(1);
              end
            end
          end
          R_JOY: begin
            // jb holds j1lo, j1hi, j2lo from oldest to newest
            jb <= {jb[15:0], rx_data};
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              joy1 <= {jb[15:8], jb[23:16]};
              joy2 <= {rx_data, jb[7:0]};
              joy_update <= 1'b1;
              st <= R_IDLE;
            end
          end
          R_STR: begin
            if (rx_data == STR_TERM) begin
              cfg_len <= cnt;
              cfg_done <= 1'b1;
              cfg_pending <= 1'b0;
              st <= R_IDLE;
            end else if (!cnt[ADDR_W]) cnt <= cnt + 1'b1;
          end
          default: st <= R_IDLE;
        endcase
      end
      if (cfg_abort) begin
        cfg_pending <= 1'b0;
        if (st == R_STR) st <= R_IDLE;
      end
    end
  end
endmodule

// File: rtl/sys_host.sv
// sys_host: initiator of the Tangcores MCU<->FPGA UART command protocol
// Ports: cmd_* command request in; data_* payload stream in (print/load); tx_* byte sink out;
// rx_* byte source in; joy1/joy2/joy_update, cfg_* parsed responses out; busy = ~cmd_ready.
// Optional SYS_HOST_TIMEOUT_EN: config response timeout with cfg_timeout pulse output.
module sys_host import sys_proto_pkg::*; #(
  parameter int STR_MAX        = 128,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [31:0]       cmd_arg,
  input  logic [23:0]       cmd_len,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [7:0]        data_byte,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [15:0]       joy1,
  output logic [15:0]       joy2,
  output logic              joy_update,
  input  logic [ADDR_W-1:0] cfg_rd_addr,
  output logic [7:0]        cfg_rd_data,
  output logic [ADDR_W:0]   cfg_len,
  output logic              cfg_done,
  output logic              busy
`ifdef SYS_HOST_TIMEOUT_EN
  ,
  output logic              cfg_timeout
`endif
);
  tx_state_t st;
  logic [2:0] op, n;
  logic [31:0] arg, arg_sh;
  logic [23:0] cnt;
  logic first, slot, cfg_pending, cfg_start, cfg_abort;
  // cnt doubles as the length argument source and the payload down-counter
  always_comb begin
    slot = !tx_valid || tx_ready;
    cmd_ready = st == TX_IDLE && !cfg_pending;
    busy = !cmd_ready;
    data_ready = (st == TX_STR || st == TX_DATA) && slot;
    cfg_start = first && tx_valid && tx_ready && op == OP_GET_CONF;
    arg_sh = (op == OP_LOAD ? {8'h00, cnt} : arg) >> {n - 3'd1, 3'b000};
  end
`ifdef SYS_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;
  logic tmo_hit;
  always_comb begin
    tmo_hit = st == TX_WAIT_CFG && !cfg_done && tmo == TW'(TIMEOUT_CYCLES - 1);
    cfg_abort = tmo_hit;
  end
  always_ff @(posedge clk) begin
    tmo <= (reset || st != TX_WAIT_CFG) ? '0 : tmo + 1'b1;
    cfg_timeout <= !reset && tmo_hit;
  end
`else
  always_comb cfg_abort = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= TX_IDLE;
      op <= '0;
      arg <= '0;
      cnt <= '0;
      n <= '0;
      first <= 1'b0;
      tx_valid <= 1'b0;
      tx_data <= '0;
    end else begin
      if (tx_ready) begin
        tx_valid <= 1'b0;
        first <= 1'b0;
      end
      case (st)
        TX_IDLE:
          if (cmd_valid && cmd_ready) begin
            op <= cmd_op;
            arg <= cmd_arg;
            cnt <= cmd_len;
            st <= cmd_op == 3'd0 ? TX_IDLE : TX_OPC;
          end
        TX_OPC:
          if (slot) begin
            tx_valid <= 1'b1;
            tx_data <= {5'd0, op};
            first <= 1'b1;
            n <= arg_bytes(op);
            st <= TX_ARGS;
          end
        TX_ARGS:
          if (n == 3'd0)
            st <= op == OP_PRINT ? TX_STR :
                  op == OP_LOAD ? (cnt == 24'd0 ? TX_IDLE : TX_DATA) :
                  op == OP_GET_CONF ? TX_WAIT_CFG : TX_IDLE;
          else if (slot) begin
            tx_valid <= 1'b1;
            tx_data <= arg_sh[7:0];
            n <= n - 3'd1;
          end
        TX_STR, TX_DATA:
          if (data_valid && data_ready) begin
            tx_valid <= 1'b1;
            tx_data <= data_byte;
            cnt <= cnt - 24'd1;
            if (st == TX_STR ? data_byte == STR_TERM : cnt == 24'd1) st <= TX_IDLE;
          end
        TX_WAIT_CFG:
          if (cfg_done || cfg_abort) st <= TX_IDLE;
        default: st <= TX_IDLE;
      endcase
    end
  end
  sys_host_rxparse #(.STR_MAX(STR_MAX), .ADDR_W(ADDR_W)) u_rx (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .cfg_start(cfg_start),
    .cfg_abort(cfg_abort),
    .cfg_pending(cfg_pending),
    .joy1(joy1),
    .joy2(joy2),
    .joy_update(joy_update),
    .cfg_rd_addr(cfg_rd_addr),
    .cfg_rd_data(cfg_rd_data),
    .cfg_len(cfg_len),
    .cfg_done(cfg_done)
  );
endmodule
